// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and default register map for the CPU MMIO bus bridge
// Contents:
//   state_t    bridge FSM states
//   dec_t      address decode result
//   ADDR_*     default peripheral register addresses (tube, buttons, IR code words)
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_REG,
        DEC_NONE
    } dec_t;

    localparam int ADDR_TUBE  = 110;
    localparam int ADDR_BTNS  = 111;
    localparam int ADDR_IR_HI = 112;
    localparam int ADDR_IR_LO = 113;

    // Number of slots in the default map, tube through IR low word.
    localparam int DEFAULT_NUM_REGS = ADDR_IR_LO - ADDR_TUBE + 1;

endpackage

// File: rtl/mmio_clear_engine.sv
// rtl/mmio_clear_engine.sv - sequential RAM clear address generator
// Ports:
//   clk, res     clock, asynchronous active-low reset
//   start        begin a clear sweep (ignored while busy)
//   busy         high while a RAM write is due this cycle at addr
//   done         one-cycle pulse the cycle after the last address was written
//   addr         current clear address
module mmio_clear_engine #(
    parameter int RAM_DEPTH = 4096,
    parameter int CNT_W     = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] addr
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAM_DEPTH - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                // Stop on the last address instead of letting the counter wrap.
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign addr = cnt;

endmodule

// File: rtl/mmio_bus_bridge.sv
// rtl/mmio_bus_bridge.sv - CPU load/store bridge to block RAM port B and a peripheral register window
// Ports:
//   clk, res                      clock, asynchronous active-low reset
//   cpu_sel/load/addr/wdata/clr   CPU request (held while cpu_stall=1)
//   cpu_rdata, cpu_rvalid         read data and one-cycle completion strobe
//   cpu_stall                     bridge busy (read in flight or RAM clear)
//   ram_addr/wdata/we, ram_rdata  RAM port B (1-cycle synchronous read)
//   reg_in, reg_out, reg_wstb     peripheral slot inputs, CPU-written values, write strobes
module mmio_bus_bridge
    import mmio_pkg::*;
#(
    parameter int                    ADDR_W    = 12,
    parameter int                    DATA_W    = 16,
    parameter int                    RAM_DEPTH = 4096,
    parameter int                    NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int                    REG_BASE  = ADDR_TUBE,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = 4'b1110,
    parameter logic [DATA_W-1:0]     CLR_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         cpu_sel,
    input  logic                         cpu_load,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic                         cpu_clr,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_rvalid,
    output logic                         cpu_stall,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic                         ram_we,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          reg_wstb
);

    localparam int CNT_W  = $clog2(RAM_DEPTH);
    localparam int SLOT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t             state, state_next;
    dec_t               dec, dec_q;
    logic [SLOT_W-1:0]  slot, slot_q;
    logic [31:0]        addr_ext;
    logic               reg_hit;
    logic               ram_hit;
    logic               accept_rd;
    logic               accept_wr;
    logic               clr_start;
    logic               clr_busy;
    logic               clr_done;
    logic [CNT_W-1:0]   clr_addr;
    logic [DATA_W-1:0]  slot_val;

    // Address decode; the register window takes precedence over RAM.
    always_comb begin
        addr_ext = 32'(cpu_addr);
        reg_hit  = (addr_ext >= 32'(REG_BASE)) && (addr_ext < 32'(REG_BASE + NUM_REGS));
        ram_hit  = !reg_hit && (addr_ext < 32'(RAM_DEPTH));
        slot     = SLOT_W'(addr_ext - 32'(REG_BASE));
        if (reg_hit)      dec = DEC_REG;
        else if (ram_hit) dec = DEC_RAM;
        else              dec = DEC_NONE;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= state_next;
    end

    // Clear wins over a bus request presented in the same cycle; that request is dropped.
    always_comb begin
        state_next = state;
        clr_start  = 1'b0;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_clr) begin
                    clr_start  = 1'b1;
                    state_next = CLEAR;
                end else if (cpu_sel) begin
                    if (cpu_load) begin
                        accept_rd  = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        accept_wr  = 1'b1;
                    end
                end
            end
            RD_WAIT: state_next = IDLE;
            CLEAR:   if (clr_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    mmio_clear_engine #(
        .RAM_DEPTH (RAM_DEPTH),
        .CNT_W     (CNT_W)
    ) u_clear (
        .clk   (clk),
        .res   (res),
        .start (clr_start),
        .busy  (clr_busy),
        .done  (clr_done),
        .addr  (clr_addr)
    );

    // RAM port B: the clear engine owns the port while busy.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = accept_wr && (dec == DEC_RAM);
        if (clr_busy) begin
            ram_addr  = ADDR_W'(clr_addr);
            ram_wdata = CLR_VALUE;
            ram_we    = 1'b1;
        end
    end

    // Read-write slots read back the CPU-written value, read-only slots the peripheral.
    always_comb begin
        if (RO_MASK[slot_q]) slot_val = reg_in[slot_q*DATA_W +: DATA_W];
        else                 slot_val = reg_out[slot_q*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dec_q      <= DEC_NONE;
            slot_q     <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            reg_out    <= '0;
            reg_wstb   <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            reg_wstb   <= '0;
            if (accept_rd) begin
                dec_q  <= dec;
                slot_q <= slot;
            end
            if (state == RD_WAIT) begin
                cpu_rvalid <= 1'b1;
                case (dec_q)
                    DEC_RAM: cpu_rdata <= ram_rdata;
                    DEC_REG: cpu_rdata <= slot_val;
                    default: cpu_rdata <= '0;
                endcase
            end
            if (accept_wr && (dec == DEC_REG) && !RO_MASK[slot]) begin
                reg_out[slot*DATA_W +: DATA_W] <= cpu_wdata;
                reg_wstb[slot]                 <= 1'b1;
            end
        end
    end

    assign cpu_stall = (state != IDLE);

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb/tb_mmio_bus_bridge.sv - directed scoreboard bench for mmio_bus_bridge
module tb_mmio_bus_bridge;

    logic        clk = 1'b0;
    logic        res;
    logic        cpu_sel, cpu_load, cpu_clr;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid, cpu_stall;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_we;
    logic [63:0] reg_in, reg_out;
    logic [3:0]  reg_wstb;

    // Second instance: 1024-word RAM, addresses >= 1024 are unmapped.
    logic        sel2;
    logic [15:0] rdata2;
    logic        rvalid2, stall2;
    logic [11:0] ram_addr2;
    logic [15:0] ram_wdata2;
    logic        ram_we2;
    logic [63:0] reg_out2;
    logic [3:0]  reg_wstb2;

    logic [15:0] mem [0:4095];
    logic [15:0] sb [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mmio_bus_bridge dut (
        .clk(clk), .res(res), .cpu_sel(cpu_sel), .cpu_load(cpu_load),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_clr(cpu_clr),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .reg_in(reg_in), .reg_out(reg_out), .reg_wstb(reg_wstb)
    );

    mmio_bus_bridge #(.RAM_DEPTH(1024)) dut2 (
        .clk(clk), .res(res), .cpu_sel(sel2), .cpu_load(cpu_load),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_clr(1'b0),
        .cpu_rdata(rdata2), .cpu_rvalid(rvalid2), .cpu_stall(stall2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2),
        .ram_rdata(16'hDEAD), .reg_in(reg_in), .reg_out(reg_out2), .reg_wstb(reg_wstb2)
    );

    // Synchronous RAM port B model, read-before-write.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed read pops the oldest expected word.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            chk("rvalid_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("rdata", cpu_rdata, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] exp);
        cpu_sel  = 1'b1;
        cpu_load = 1'b1;
        cpu_addr = a;
        sb.push_back(exp);
        #1;
        chk($sformatf("rd_stall_pre@%0d", a), cpu_stall, 0);
        chk($sformatf("rd_ram_addr@%0d", a), ram_addr, a);
        @(posedge clk);
        #1;
        cpu_sel = 1'b0;
        chk($sformatf("rd_stall_wait@%0d", a), cpu_stall, 1);
        chk($sformatf("rd_rvalid_early@%0d", a), cpu_rvalid, 0);
        tick();
        chk($sformatf("rd_rvalid@%0d", a), cpu_rvalid, 1);
        chk($sformatf("rd_stall_done@%0d", a), cpu_stall, 0);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d, input logic exp_we);
        cpu_sel   = 1'b1;
        cpu_load  = 1'b0;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        chk($sformatf("wr_we@%0d", a), ram_we, exp_we);
        chk($sformatf("wr_stall@%0d", a), cpu_stall, 0);
        if (exp_we) begin
            chk($sformatf("wr_addr@%0d", a), ram_addr, a);
            chk($sformatf("wr_data@%0d", a), ram_wdata, d);
        end
        @(posedge clk);
        #1;
        cpu_sel = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        res       = 1'b0;
        cpu_sel   = 1'b0;
        cpu_load  = 1'b0;
        cpu_clr   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        sel2      = 1'b0;
        reg_in    = {16'h0113, 16'h0112, 16'h000A, 16'hAAAA};

        repeat (2) tick();
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_wstb", reg_wstb, 0);
        chk("rst_ram_we", ram_we, 0);
        res = 1'b1;
        tick();

        // RAM write then read-back.
        do_write(12'd5, 16'hBEEF, 1'b1);
        do_read(12'd5, 16'hBEEF);

        // Read/write slot 0.
        do_write(12'd110, 16'h1234, 1'b0);
        chk("slot0_reg_out", reg_out[15:0], 16'h1234);
        chk("slot0_wstb", reg_wstb, 4'b0001);
        tick();
        chk("slot0_wstb_single", reg_wstb, 4'b0000);
        do_read(12'd110, 16'h1234);

        // Read-only slot 1 ignores writes and returns the peripheral value.
        do_write(12'd111, 16'hFFFF, 1'b0);
        chk("slot1_wstb", reg_wstb, 4'b0000);
        chk("slot1_reg_out", reg_out[31:16], 16'h0000);
        do_read(12'd111, 16'h000A);
        do_read(12'd113, 16'h0113);

        // Window edges: 109 and 114 are RAM; back-to-back writes.
        do_write(12'd109, 16'h0109, 1'b1);
        do_write(12'd114, 16'h7777, 1'b1);
        do_write(12'd0, 16'h1111, 1'b1);
        do_write(12'd2000, 16'h2222, 1'b1);
        do_write(12'd4095, 16'h3333, 1'b1);
        do_read(12'd109, 16'h0109);
        do_read(12'd114, 16'h7777);
        do_read(12'd0, 16'h1111);
        do_read(12'd2000, 16'h2222);
        do_read(12'd4095, 16'h3333);

        // Smaller instance: 2000 is unmapped.
        sel2     = 1'b1;
        cpu_load = 1'b1;
        cpu_addr = 12'd2000;
        #1;
        chk("d2_rd_we", ram_we2, 0);
        tick();
        sel2 = 1'b0;
        chk("d2_stall", stall2, 1);
        tick();
        chk("d2_rvalid", rvalid2, 1);
        chk("d2_rdata", rdata2, 0);
        sel2      = 1'b1;
        cpu_load  = 1'b0;
        cpu_wdata = 16'h5A5A;
        #1;
        chk("d2_wr_we", ram_we2, 0);
        tick();
        sel2 = 1'b0;

        // Full clear; a second cpu_clr mid-sweep must be ignored.
        cpu_clr = 1'b1;
        #1;
        chk("clr_req_we", ram_we, 0);
        tick();
        cpu_clr = 1'b0;
        n = 0;
        while (cpu_stall && n < 5000) begin
            n++;
            cpu_clr = (n == 10);
            if (n == 5) begin
                chk("clr_we", ram_we, 1);
                chk("clr_addr", ram_addr, 4);
                chk("clr_wdata", ram_wdata, 0);
            end
            tick();
        end
        cpu_clr = 1'b0;
        chk("clr_stall_cycles", n, 4097);
        chk("clr_reg_out_kept", reg_out[15:0], 16'h1234);
        do_read(12'd0, 16'h0000);
        do_read(12'd2000, 16'h0000);
        do_read(12'd4095, 16'h0000);

        // Reset during a clear, with a write presented alongside cpu_clr.
        do_write(12'd3000, 16'h4444, 1'b1);
        do_write(12'd50, 16'h5555, 1'b1);
        cpu_clr   = 1'b1;
        cpu_sel   = 1'b1;
        cpu_load  = 1'b0;
        cpu_addr  = 12'd3500;
        cpu_wdata = 16'h6666;
        #1;
        chk("clr_sel_we", ram_we, 0);
        tick();
        cpu_clr = 1'b0;
        cpu_sel = 1'b0;
        repeat (100) tick();
        chk("midclr_stall", cpu_stall, 1);
        #2;
        res = 1'b0;
        #1;
        chk("arst_stall", cpu_stall, 0);
        chk("arst_rvalid", cpu_rvalid, 0);
        chk("arst_reg_out", reg_out, 0);
        chk("arst_ram_we", ram_we, 0);
        tick();
        res = 1'b1;
        tick();
        do_read(12'd50, 16'h0000);
        do_read(12'd3000, 16'h4444);
        do_read(12'd3500, 16'h0000);
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
